// File: rtl/mem_line_bridge.sv
// mem_line_bridge
// Bridges one level-held cache-line request from the L1 arbiter onto a narrow,
// beat-based memory bus. Stores are serialised into BEATS beats, and loads are
// reassembled from returned beats. Every captured request finishes with a
// single-cycle response pulse that echoes the request tag and opcode.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   mem_req_*             level request (valid/addr/store_data/tag/opcode/insn)
//   mem_req_ack           one-cycle pulse when the request is captured
//   mem_rsp_*             one-cycle response pulse with load data, tag and opcode
//   bus_cmd_*             command channel (valid/ready, addr, write, insn hint)
//   bus_wdata*            write-beat channel (valid/ready)
//   bus_wr_done           write completion pulse
//   bus_rdata_valid/rdata read beats (no backpressure)
//   err_bad_opcode        sticky flag: an unknown opcode was captured
module mem_line_bridge #(
  parameter int         ADDR_W        = 64,
  parameter int         LINE_BITS     = 128,
  parameter int         BEAT_BITS     = 64,
  parameter int         TAG_W         = 2,
  parameter logic [4:0] OP_LOAD_LINE  = 5'd4,
  parameter logic [4:0] OP_STORE_LINE = 5'd7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  input  logic [ADDR_W-1:0]    mem_req_addr,
  input  logic [LINE_BITS-1:0] mem_req_store_data,
  input  logic [TAG_W-1:0]     mem_req_tag,
  input  logic [4:0]           mem_req_opcode,
  input  logic                 mem_req_insn,
  output logic                 mem_req_ack,
  output logic                 mem_rsp_valid,
  output logic [LINE_BITS-1:0] mem_rsp_load_data,
  output logic [TAG_W-1:0]     mem_rsp_tag,
  output logic [4:0]           mem_rsp_opcode,
  output logic                 bus_cmd_valid,
  input  logic                 bus_cmd_ready,
  output logic [ADDR_W-1:0]    bus_cmd_addr,
  output logic                 bus_cmd_write,
  output logic                 bus_cmd_insn,
  output logic                 bus_wdata_valid,
  input  logic                 bus_wdata_ready,
  output logic [BEAT_BITS-1:0] bus_wdata,
  input  logic                 bus_wr_done,
  input  logic                 bus_rdata_valid,
  input  logic [BEAT_BITS-1:0] bus_rdata,
  output logic                 err_bad_opcode
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_BITS / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CMD, S_WDATA, S_WWAIT, S_RDATA, S_RSP
  } state_t;

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [LINE_BITS-1:0]  r_wline;
  logic [LINE_BITS-1:0]  r_rline;
  logic [TAG_W-1:0]      r_tag;
  logic [4:0]            r_op;
  logic                  r_insn;
  logic [LINE_BITS-1:0]  r_rsp_data;
  logic [TAG_W-1:0]      r_rsp_tag;
  logic [4:0]            r_rsp_op;
  logic                  r_err;

  logic [ADDR_W-1:0]     w_addr_aligned;
  logic [LINE_BITS-1:0]  w_rline_merged;
  logic                  w_in_known;
  logic                  w_is_store;
  logic                  w_last_beat;
  logic [BEAT_BITS-1:0]  w_wbeats [BEATS];

  assign w_in_known  = (mem_req_opcode == OP_LOAD_LINE) || (mem_req_opcode == OP_STORE_LINE);
  assign w_is_store  = (r_op == OP_STORE_LINE);
  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

  // Beat k of the captured writeback line, lowest beat first.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
      assign w_wbeats[gi] = r_wline[gi*BEAT_BITS +: BEAT_BITS];
    end
  endgenerate

  always_comb begin
    w_addr_aligned = mem_req_addr;
    w_addr_aligned[OFF_W-1:0] = '0;
  end

  // Read line with the incoming beat dropped into slot r_cnt.
  always_comb begin
    w_rline_merged = r_rline;
    for (int k = 0; k < BEATS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_rline_merged[k*BEAT_BITS +: BEAT_BITS] = bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    mem_req_ack     = 1'b0;
    mem_rsp_valid   = 1'b0;
    bus_cmd_valid   = 1'b0;
    bus_wdata_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The arbiter's address mux settles one cycle after valid rises.
        if (mem_req_valid) w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!mem_req_valid) begin
          w_state_next = S_IDLE;
        end else begin
          mem_req_ack  = 1'b1;
          w_state_next = w_in_known ? S_CMD : S_RSP;
        end
      end
      S_CMD: begin
        bus_cmd_valid = 1'b1;
        if (bus_cmd_ready) w_state_next = w_is_store ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        bus_wdata_valid = 1'b1;
        if (bus_wdata_ready && w_last_beat) w_state_next = bus_wr_done ? S_RSP : S_WWAIT;
      end
      S_WWAIT: begin
        if (bus_wr_done) w_state_next = S_RSP;
      end
      S_RDATA: begin
        if (bus_rdata_valid && w_last_beat) w_state_next = S_RSP;
      end
      S_RSP: begin
        mem_rsp_valid = 1'b1;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wline    <= '0;
      r_rline    <= '0;
      r_tag      <= '0;
      r_op       <= '0;
      r_insn     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_tag  <= '0;
      r_rsp_op   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_SETTLE && mem_req_valid) begin
        r_addr  <= w_addr_aligned;
        r_wline <= mem_req_store_data;
        r_tag   <= mem_req_tag;
        r_op    <= mem_req_opcode;
        r_insn  <= mem_req_insn;
        r_rline <= '0;
        if (!w_in_known) r_err <= 1'b1;
      end
      if (r_state == S_CMD && bus_cmd_ready) r_cnt <= '0;
      if ((r_state == S_WDATA && bus_wdata_ready) || (r_state == S_RDATA && bus_rdata_valid)) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
      end
      if (r_state == S_RDATA && bus_rdata_valid) r_rline <= w_rline_merged;
      // Response fields are loaded on entry to RSP and held until the next one.
      if (w_state_next == S_RSP && r_state != S_RSP) begin
        r_rsp_data <= (r_state == S_RDATA) ? w_rline_merged : '0;
        r_rsp_tag  <= (r_state == S_SETTLE) ? mem_req_tag : r_tag;
        r_rsp_op   <= (r_state == S_SETTLE) ? mem_req_opcode : r_op;
      end
    end
  end

  assign bus_cmd_addr      = r_addr;
  assign bus_cmd_write     = w_is_store;
  assign bus_cmd_insn      = r_insn;
  assign bus_wdata         = w_wbeats[r_cnt];
  assign mem_rsp_load_data = r_rsp_data;
  assign mem_rsp_tag       = r_rsp_tag;
  assign mem_rsp_opcode    = r_rsp_op;
  assign err_bad_opcode    = r_err;

endmodule

// File: tb/tb_mem_line_bridge.sv
module tb_mem_line_bridge;
  localparam int ADDR_W    = 64;
  localparam int LINE_BITS = 128;
  localparam int BEAT_BITS = 64;
  localparam int TAG_W     = 2;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
  localparam logic [4:0] OP_LD = 5'd4;
  localparam logic [4:0] OP_ST = 5'd7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mem_req_valid;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic [LINE_BITS-1:0] mem_req_store_data;
  logic [TAG_W-1:0]     mem_req_tag;
  logic [4:0]           mem_req_opcode;
  logic                 mem_req_insn;
  logic                 mem_req_ack;
  logic                 mem_rsp_valid;
  logic [LINE_BITS-1:0] mem_rsp_load_data;
  logic [TAG_W-1:0]     mem_rsp_tag;
  logic [4:0]           mem_rsp_opcode;
  logic                 bus_cmd_valid;
  logic                 bus_cmd_ready;
  logic [ADDR_W-1:0]    bus_cmd_addr;
  logic                 bus_cmd_write;
  logic                 bus_cmd_insn;
  logic                 bus_wdata_valid;
  logic                 bus_wdata_ready;
  logic [BEAT_BITS-1:0] bus_wdata;
  logic                 bus_wr_done;
  logic                 bus_rdata_valid;
  logic [BEAT_BITS-1:0] bus_rdata;
  logic                 err_bad_opcode;

  always #5 clk = ~clk;

  mem_line_bridge #(
    .ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS), .BEAT_BITS(BEAT_BITS), .TAG_W(TAG_W),
    .OP_LOAD_LINE(OP_LD), .OP_STORE_LINE(OP_ST)
  ) u_dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_store_data(mem_req_store_data), .mem_req_tag(mem_req_tag),
    .mem_req_opcode(mem_req_opcode), .mem_req_insn(mem_req_insn),
    .mem_req_ack(mem_req_ack), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_load_data(mem_rsp_load_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_opcode(mem_rsp_opcode),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
    .bus_cmd_addr(bus_cmd_addr), .bus_cmd_write(bus_cmd_write), .bus_cmd_insn(bus_cmd_insn),
    .bus_wdata_valid(bus_wdata_valid), .bus_wdata_ready(bus_wdata_ready), .bus_wdata(bus_wdata),
    .bus_wr_done(bus_wr_done), .bus_rdata_valid(bus_rdata_valid), .bus_rdata(bus_rdata),
    .err_bad_opcode(err_bad_opcode)
  );

  typedef struct {
    logic [63:0]  addr;
    logic [127:0] line;      // store data, or the beats the bus returns for a load
    logic [1:0]   tag;
    logic [4:0]   op;
    logic         insn;
    int           cmd_wait;  // cycles cmd_ready is held low
    int           wstall;    // cycles wdata_ready is held low before each beat
    int           done_dly;  // cycles from last write beat to wr_done (0 = same cycle)
    int           rgap;      // idle cycles between read beats
    logic [63:0]  exp_addr;
    logic [127:0] exp_data;
    int           exp_cyc;   // required response cycle, -1 = derive from bus events
  } txn_t;

  int   n_pass = 0;
  int   n_total = 0;
  logic err_exp = 1'b0;
  int   txn_no = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] beat(input logic [127:0] l, input int k);
    return l[k*BEAT_BITS +: BEAT_BITS];
  endfunction

  function automatic txn_t mk(input logic [63:0] addr, input logic [127:0] line,
                              input logic [1:0] tag, input logic [4:0] op, input logic insn,
                              input int cw, input int ws, input int dd, input int rg,
                              input logic [63:0] ea, input logic [127:0] ed, input int ec);
    txn_t t;
    t.addr = addr; t.line = line; t.tag = tag; t.op = op; t.insn = insn;
    t.cmd_wait = cw; t.wstall = ws; t.done_dly = dd; t.rgap = rg;
    t.exp_addr = ea; t.exp_data = ed; t.exp_cyc = ec;
    return t;
  endfunction

  task automatic clear_bus();
    bus_cmd_ready = 1'b0; bus_wdata_ready = 1'b0; bus_wr_done = 1'b0;
    bus_rdata_valid = 1'b0; bus_rdata = '0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ack"}, mem_req_ack, 0);
    chk({pfx, "_rsp_valid"}, mem_rsp_valid, 0);
    chk({pfx, "_rsp_data"}, mem_rsp_load_data, 0);
    chk({pfx, "_rsp_tag"}, mem_rsp_tag, 0);
    chk({pfx, "_rsp_op"}, mem_rsp_opcode, 0);
    chk({pfx, "_cmd_valid"}, bus_cmd_valid, 0);
    chk({pfx, "_cmd_addr"}, bus_cmd_addr, 0);
    chk({pfx, "_cmd_write"}, bus_cmd_write, 0);
    chk({pfx, "_cmd_insn"}, bus_cmd_insn, 0);
    chk({pfx, "_wdata_valid"}, bus_wdata_valid, 0);
    chk({pfx, "_wdata"}, bus_wdata, 0);
    chk({pfx, "_err"}, err_bad_opcode, 0);
  endtask

  // Acts as both the requesting arbiter and the memory bus for one transaction.
  task automatic run_txn(input txn_t t);
    logic is_ld, is_st, bad;
    int cmd_seen, cmd_first, cmd_acc, wst, wacc, last_w, rsent, gap, exp_cyc;
    int rsp_cyc, stray_ack, cmd_bad, wd_bad;
    bit done;
    is_ld = (t.op == OP_LD); is_st = (t.op == OP_ST); bad = !(is_ld || is_st);
    cmd_seen = 0; cmd_first = -1; cmd_acc = -1; wst = 0; wacc = 0; last_w = -1;
    rsent = 0; gap = 0; rsp_cyc = -1; stray_ack = 0; cmd_bad = 0; wd_bad = 0; done = 0;
    exp_cyc = bad ? 2 : -1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge clk); #2;
      clear_bus();
      if (cyc == 0) begin
        mem_req_addr = t.addr; mem_req_store_data = t.line; mem_req_tag = t.tag;
        mem_req_opcode = t.op; mem_req_insn = t.insn; mem_req_valid = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        chk("idle_ack", mem_req_ack, 0);
        chk("idle_rsp", mem_rsp_valid, 0);
        chk("idle_cmd", bus_cmd_valid, 0);
      end else if (cyc == 1) chk("ack", mem_req_ack, 1);
      else if (mem_req_ack) stray_ack++;
      if (bus_cmd_valid) begin
        if (cmd_acc >= 0) cmd_bad++;
        if (cmd_first < 0) begin
          cmd_first = cyc;
          chk("cmd_addr", bus_cmd_addr, t.exp_addr);
          chk("cmd_write", bus_cmd_write, is_st);
          chk("cmd_insn", bus_cmd_insn, t.insn);
        end else if (bus_cmd_addr !== t.exp_addr || bus_cmd_write !== is_st) cmd_bad++;
        bus_cmd_ready = (cmd_seen >= t.cmd_wait);
        cmd_seen++;
        if (bus_cmd_ready) cmd_acc = cyc;
      end
      if (bus_wdata_valid) begin
        if (!is_st || wacc >= BEATS) wd_bad++;
        else begin
          chk($sformatf("wbeat%0d", wacc), bus_wdata, beat(t.line, wacc));
          bus_wdata_ready = (wst >= t.wstall);
          if (bus_wdata_ready) begin
            wacc++; wst = 0;
            if (wacc == BEATS) last_w = cyc;
          end else wst++;
        end
      end
      if (is_st && last_w >= 0 && cyc == last_w + t.done_dly) begin
        bus_wr_done = 1'b1; exp_cyc = cyc + 1;
      end
      if (is_ld && cmd_acc >= 0 && cyc > cmd_acc && rsent < BEATS) begin
        if (gap == 0) begin
          bus_rdata_valid = 1'b1; bus_rdata = beat(t.line, rsent);
          rsent++; gap = t.rgap;
          if (rsent == BEATS) exp_cyc = cyc + 1;
        end else gap--;
      end else if (is_ld && cmd_acc < 0 && $urandom_range(1) == 1) begin
        // Spurious beats before the command is accepted must be ignored.
        bus_rdata_valid = 1'b1; bus_rdata = {$urandom, $urandom};
      end
      if (mem_rsp_valid) begin
        rsp_cyc = cyc; done = 1; mem_req_valid = 1'b0;
        chk("rsp_cycle", rsp_cyc, exp_cyc);
        if (t.exp_cyc >= 0) chk("rsp_latency", rsp_cyc, t.exp_cyc);
        chk("rsp_data", mem_rsp_load_data, t.exp_data);
        chk("rsp_tag", mem_rsp_tag, t.tag);
        chk("rsp_op", mem_rsp_opcode, t.op);
      end
    end
    mem_req_valid = 1'b0;
    chk("rsp_seen", done, 1);
    chk("stray_ack", stray_ack, 0);
    chk("cmd_proto", cmd_bad, 0);
    chk("wdata_proto", wd_bad, 0);
    chk("cmd_first", cmd_first, bad ? -1 : 2);
    if (is_st) chk("wbeats_sent", wacc, BEATS);
    err_exp = err_exp | bad;
    chk("err_flag", err_bad_opcode, err_exp);
    $display("txn %0d op=%0d tag=%0d insn=%0d addr=%h rsp_cycle=%0d data=%h",
             txn_no, t.op, t.tag, t.insn, t.addr, rsp_cyc, mem_rsp_load_data);
    txn_no++;
  endtask

  txn_t tbl[5];

  initial begin
    txn_t t;
    logic [4:0] op;
    tbl[0] = mk(64'h1008, {64'hBBBB, 64'hAAAA}, 2'd2, OP_LD, 1'b0, 0, 0, 0, 0,
                64'h1000, {64'hBBBB, 64'hAAAA}, 3 + BEATS);
    tbl[1] = mk(64'h2000, {64'h22, 64'h11}, 2'd1, OP_ST, 1'b0, 1, 3, 2, 0,
                64'h2000, 128'h0, -1);
    tbl[2] = mk(64'h3000, {64'h5, 64'h6}, 2'd3, 5'd9, 1'b0, 0, 0, 0, 0,
                64'h3000, 128'h0, 2);
    tbl[3] = mk(64'h4_0034, {64'hCAFE_0001, 64'hF00D_0002}, 2'd1, OP_LD, 1'b1, 2, 0, 0, 1,
                64'h4_0030, {64'hCAFE_0001, 64'hF00D_0002}, -1);
    tbl[4] = mk(64'h5_00F0, {64'h1234_5678, 64'h9ABC_DEF0}, 2'd3, OP_ST, 1'b0, 0, 0, 0, 0,
                64'h5_00F0, 128'h0, -1);

    mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_store_data = '0;
    mem_req_tag = '0; mem_req_opcode = '0; mem_req_insn = 1'b0;
    clear_bus();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 chk_zero("por");
    @(negedge clk); reset = 1'b1;

    // Directed table, applied back to back.
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Valid held for one cycle only: dropped while settling.
    @(posedge clk); #2;
    mem_req_addr = 64'h6000; mem_req_opcode = OP_LD; mem_req_tag = 2'd2; mem_req_valid = 1'b1;
    @(posedge clk); #2; mem_req_valid = 1'b0;
    #1 chk("drop_ack", mem_req_ack, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("drop_cmd", bus_cmd_valid, 0);
      chk("drop_rsp", mem_rsp_valid, 0);
      chk("drop_ack_late", mem_req_ack, 0);
    end

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 30; i++) begin
      t.addr = {$urandom, $urandom};
      t.line = {$urandom, $urandom, $urandom, $urandom};
      t.tag = 2'($urandom_range(3));
      op = ($urandom_range(1) == 1) ? OP_LD : OP_ST;
      if ($urandom_range(9) == 0) op = 5'($urandom_range(31));
      t.op = op;
      t.insn = 1'($urandom_range(1));
      t.cmd_wait = $urandom_range(3); t.wstall = $urandom_range(3);
      t.done_dly = $urandom_range(3); t.rgap = $urandom_range(3);
      t.exp_addr = t.addr & ~64'hF;
      t.exp_data = (op == OP_LD) ? t.line : 128'h0;
      t.exp_cyc = -1;
      run_txn(t);
    end

    // Reset while collecting read beats, after beat 0 has landed.
    @(posedge clk); #2;
    mem_req_addr = 64'h7040; mem_req_opcode = OP_LD; mem_req_tag = 2'd1;
    mem_req_insn = 1'b0; mem_req_valid = 1'b1;
    @(posedge clk); #3 chk("rst_seq_ack", mem_req_ack, 1);
    @(posedge clk); #2 bus_cmd_ready = 1'b1;
    #1 chk("rst_seq_cmd", bus_cmd_valid, 1);
    @(posedge clk); #2 clear_bus();
    bus_rdata_valid = 1'b1; bus_rdata = 64'hDEAD_BEEF_0BAD_0BAD;
    @(posedge clk); #2 clear_bus();
    mem_req_valid = 1'b0;
    reset = 1'b0;
    #1 chk_zero("rst_mid");
    @(posedge clk); #3 chk_zero("rst_hold");
    @(negedge clk); reset = 1'b1;
    err_exp = 1'b0;
    run_txn(mk(64'h7048, {64'h1111_2222, 64'h3333_4444}, 2'd2, OP_LD, 1'b0, 0, 0, 0, 0,
               64'h7040, {64'h1111_2222, 64'h3333_4444}, 3 + BEATS));

    @(posedge clk); #3;
    chk("end_rsp", mem_rsp_valid, 0);
    chk("end_cmd", bus_cmd_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_line_bridge.md
Name: mem_line_bridge

Overview:
- Sits directly downstream of the core/L1 memory port, between the L1D/L1I arbiter and the off-core memory bus.
- Takes one level-held cache-line request at a time and issues a command to a narrow beat-based bus.
- For stores, it serialises the line into beats; for loads, it collects returned beats into a line.
- Returns a one-cycle response pulse, echoing the request tag and opcode.

Parameters:
ADDR_W, 64, address width (M_WIDTH)
LINE_BITS, 128, cache-line width (L1D_CL_LEN_BITS)
BEAT_BITS, 64, bus data-beat width; LINE_BITS must be a multiple of BEAT_BITS
TAG_W, 2, request tag width (LG_MEM_TAG_ENTRIES)
OP_LOAD_LINE, 5'd4, line-fill opcode
OP_STORE_LINE, 5'd7, line-writeback opcode

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
mem_req_valid  in  1  level request from arbiter; held until the response cycle
mem_req_addr  in  ADDR_W  line address
mem_req_store_data  in  LINE_BITS  writeback data
mem_req_tag  in  TAG_W  request tag
mem_req_opcode  in  5  line opcode
mem_req_insn  in  1  request is from the L1I
mem_req_ack  out  1  one-cycle pulse when the request is captured
mem_rsp_valid  out  1  one-cycle response pulse
mem_rsp_load_data  out  LINE_BITS  assembled line (zero for stores)
mem_rsp_tag  out  TAG_W  captured tag
mem_rsp_opcode  out  5  captured opcode
bus_cmd_valid  out  1  bus command valid
bus_cmd_ready  in  1  bus command accept
bus_cmd_addr  out  ADDR_W  line-aligned address
bus_cmd_write  out  1  1 = writeback
bus_cmd_insn  out  1  instruction-fetch hint
bus_wdata_valid  out  1  write beat valid
bus_wdata_ready  in  1  write beat accept
bus_wdata  out  BEAT_BITS  write beat
bus_wr_done  in  1  write completion pulse
bus_rdata_valid  in  1  read beat valid (no backpressure)
bus_rdata  in  BEAT_BITS  read beat
err_bad_opcode  out  1  sticky unknown-opcode flag

Behaviour:
- Reset, asynchronous and active-low: FSM goes to IDLE; beat counter, captured fields and all outputs go to 0, including mem_rsp_load_data and err_bad_opcode. A reset mid-transaction abandons it with no response.
- BEATS = LINE_BITS/BEAT_BITS. Beat k carries bits [k*BEAT_BITS +: BEAT_BITS], transferred in ascending order.
- FSM states: IDLE, SETTLE, CMD, WDATA, WWAIT, RDATA, RSP.
- IDLE: if mem_req_valid → SETTLE. Nothing is captured here, because the arbiter's address mux switches one cycle after valid rises.
- SETTLE:
  - If mem_req_valid is still high: capture addr (low log2(LINE_BITS/8) bits forced to 0), store data, tag, opcode and insn. Pulse mem_req_ack.
  - Opcode OP_LOAD_LINE or OP_STORE_LINE → CMD.
  - Any other opcode → set err_bad_opcode, go to RSP with zero data.
  - If mem_req_valid has dropped → IDLE with no ack.
- CMD: bus_cmd_valid=1, with address, write and insn driven from the captured fields and stable until accepted. When bus_cmd_ready: store → WDATA, load → RDATA, beat counter cleared.
- WDATA:
  - bus_wdata_valid=1; bus_wdata = captured beat[counter].
  - Counter increments on each ready.
  - After the last beat is accepted → WWAIT. If bus_wr_done is already high in that same cycle → RSP directly.
- WWAIT: wait for bus_wr_done → RSP.
- RDATA:
  - Each bus_rdata_valid writes beat[counter] of an internal line register; counter increments.
  - After the final beat → RSP. The counter wraps to 0.
  - bus_rdata_valid outside RDATA is ignored.
- RSP:
  - mem_rsp_valid=1 for exactly one cycle, then → IDLE.
  - Tag and opcode echo the captured values.
  - mem_rsp_load_data shows the assembled line for loads, 0 for stores and bad opcodes.
  - Rsp fields hold their values until the next RSP.
- Once captured, a request always completes, even if mem_req_valid drops early.
- Only one transaction is outstanding. A new request is detected in IDLE only; the arbiter lowers valid in the response cycle.
- Load latency, with ready bus and back-to-back beats:
  - valid rises at cycle t.
  - ack and capture at t+1.
  - cmd accepted at t+2.
  - beats arrive at t+3..t+2+BEATS.
  - rsp at t+3+BEATS.

Test Plan:
- Load: addr 0x1008, tag 2, op 4, insn 0. Immediate cmd_ready, rdata beats 0xAAAA then 0xBBBB on consecutive cycles → bus_cmd_addr 0x1000 at t+2, mem_rsp_valid at t+5, data {0xBBBB,0xAAAA}, tag 2, op 4.
- Store: addr 0x2000, data {0x22,0x11}, op 7, wdata_ready low for 3 cycles, then wr_done 2 cycles after the last beat → beats 0x11 then 0x22, each stable while stalled, one rsp pulse with data 0.
- Valid high for only 1 cycle, dropped in SETTLE → no ack, no bus_cmd_valid, back to IDLE.
- Opcode 5'd9 → ack, err_bad_opcode=1 and remains set, rsp one cycle later with zero data, no bus activity.
- Reset asserted in RDATA after beat 0 → all outputs 0 immediately. The next load completes normally with no stale data from the old beat.
- Back-to-back: L1I load with insn=1, followed immediately by an L1D store → bus_cmd_insn is 1 then 0, two rsp pulses with the correct tags, no overlap of transactions.
